// File: rtl/dbg_out_sequencer_if.sv
// Bundle between the board (buttons, dwell, selector output) and the debug
// output sequencer (select, mode, display latch).
interface dbg_out_sequencer_if #(
   parameter int unsigned D_SIZE  = 32,
   parameter int unsigned DWELL_W = 8
);
   logic                btn_next;
   logic                btn_mode;
   logic [DWELL_W-1:0]  dwell;
   logic [D_SIZE-1:0]   mux_out;
   logic [1:0]          sel_out;
   logic [1:0]          mode;
   logic [D_SIZE-1:0]   disp;
   logic                disp_valid;

   modport master (
      output btn_next, btn_mode, dwell, mux_out,
      input  sel_out, mode, disp, disp_valid
   );

   modport slave (
      input  btn_next, btn_mode, dwell, mux_out,
      output sel_out, mode, disp, disp_valid
   );
endinterface

// File: rtl/dbg_out_sequencer.sv
// Debug output sequencer: debounced next/mode buttons drive the selector
// select (manual step, timed auto-scan, freeze) and a registered display latch.
module dbg_out_sequencer #(
   parameter int unsigned D_SIZE    = 32,
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned DWELL_W   = 8
) (
   input logic                clk,
   input logic                rst_n,
   dbg_out_sequencer_if.slave bus
);
   localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_AUTO   = 2'b01,
      MODE_FREEZE = 2'b10
   } mode_e;

   // bit 0: next button, bit 1: mode button
   logic [1:0]          btn_raw;
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          deb_q, deb_d, deb_prev_q;
   logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;
   logic                next_p, mode_p;

   mode_e               mode_q, mode_d;
   logic [1:0]          sel_q, sel_d;
   logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic [D_SIZE-1:0]   disp_q, disp_d;
   logic                disp_valid_q, disp_valid_d;

   assign btn_raw = {bus.btn_mode, bus.btn_next};
   assign next_p  = deb_q[0] & ~deb_prev_q[0];
   assign mode_p  = deb_q[1] & ~deb_prev_q[1];

   // Counter only runs while the synced level disagrees with the accepted one.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      mode_d       = mode_q;
      sel_d        = sel_q;
      dwell_cnt_d  = dwell_cnt_q;
      disp_d       = disp_q;
      disp_valid_d = disp_valid_q;

      // mode_p takes priority; a coincident next_p is dropped.
      case (mode_q)
         MODE_MANUAL: begin
            if (mode_p) begin
               mode_d      = MODE_AUTO;
               dwell_cnt_d = '0;
            end else if (next_p) begin
               sel_d = sel_q + 2'd1;
            end
         end
         MODE_AUTO: begin
            if (mode_p) begin
               mode_d      = MODE_FREEZE;
               dwell_cnt_d = '0;
            end else if (next_p || (dwell_cnt_q >= bus.dwell)) begin
               sel_d       = sel_q + 2'd1;
               dwell_cnt_d = '0;
            end else begin
               dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
         end
         MODE_FREEZE: begin
            dwell_cnt_d = '0;
            if (mode_p) begin
               mode_d = MODE_MANUAL;
            end
         end
         default: begin
            mode_d      = MODE_MANUAL;
            dwell_cnt_d = '0;
         end
      endcase

      if (mode_q != MODE_FREEZE) begin
         disp_d       = bus.mux_out;
         disp_valid_d = (sel_d == sel_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_prev_q   <= '0;
         db_cnt_q     <= '0;
         mode_q       <= MODE_MANUAL;
         sel_q        <= '0;
         dwell_cnt_q  <= '0;
         disp_q       <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         deb_prev_q   <= deb_q;
         db_cnt_q     <= db_cnt_d;
         mode_q       <= mode_d;
         sel_q        <= sel_d;
         dwell_cnt_q  <= dwell_cnt_d;
         disp_q       <= disp_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign bus.sel_out    = sel_q;
   assign bus.mode       = mode_q;
   assign bus.disp       = disp_q;
   assign bus.disp_valid = disp_valid_q;
endmodule

// File: tb/tb_dbg_out_sequencer.sv
// Scoreboard bench for dbg_out_sequencer: expected select changes (value and
// edge number) are queued when buttons are driven and popped as sel_out moves.
module tb_dbg_out_sequencer;
   typedef struct {
      logic [1:0]  sel;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] words [4];
   exp_t        sb_q [$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          mon_en = 1'b0;
   bit          pend = 1'b0;
   logic [1:0]  prev_sel = 2'b00;

   dbg_out_sequencer_if #(.D_SIZE(32), .DWELL_W(8)) bus ();

   dbg_out_sequencer #(
      .D_SIZE   (32),
      .DB_CYCLES(4),
      .DWELL_W  (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Combinational selector model
   assign bus.mux_out = words[bus.sel_out];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [1:0] sel, input int unsigned at);
      exp_t x;
      x.sel = sel;
      x.cyc = at;
      sb_q.push_back(x);
   endtask

   task automatic wait_until(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic press_next(input logic [1:0] exp_sel);
      int unsigned e;
      e = cyc;
      bus.btn_next = 1'b1;
      push_exp(exp_sel, e + 7);
      wait_until(e + 10);
      bus.btn_next = 1'b0;
      wait_until(e + 20);
      check_eq("press_drain", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: every sel_out change must match the head of the scoreboard
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (bus.sel_out != prev_sel) begin
            if (sb_q.size() == 0) begin
               check_eq("sel_hold", 32'(bus.sel_out), 32'(prev_sel));
            end else begin
               e = sb_q.pop_front();
               check_eq("sel_val", 32'(bus.sel_out), 32'(e.sel));
               check_eq("sel_edge", cyc, e.cyc);
            end
            check_eq("valid_low", 32'(bus.disp_valid), 32'd0);
            pend = 1'b1;
         end else begin
            if (pend) begin
               check_eq("disp_new", bus.disp, words[bus.sel_out]);
               check_eq("valid_high", 32'(bus.disp_valid), 32'd1);
            end
            pend = 1'b0;
         end
      end else begin
         pend = 1'b0;
      end
      prev_sel = bus.sel_out;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k, e, m;
      rst_n        = 1'b0;
      bus.btn_next = 1'b0;
      bus.btn_mode = 1'b0;
      bus.dwell    = 8'd3;
      words[0]     = 32'hDEAD_BEEF;
      words[1]     = 32'h1111_0001;
      words[2]     = 32'h0000_1234;
      words[3]     = 32'hCAFE_0003;

      // Reset and first capture
      repeat (3) @(negedge clk);
      check_eq("rst_sel", 32'(bus.sel_out), 32'd0);
      check_eq("rst_mode", 32'(bus.mode), 32'd0);
      check_eq("rst_disp", bus.disp, 32'd0);
      check_eq("rst_valid", 32'(bus.disp_valid), 32'd0);
      rst_n = 1'b1;
      k = cyc;
      wait_until(k + 1);
      check_eq("cap_disp", bus.disp, 32'hDEAD_BEEF);
      check_eq("cap_valid", 32'(bus.disp_valid), 32'd1);
      mon_en = 1'b1;

      // Glitch of 3 cycles: no step
      e = cyc;
      bus.btn_next = 1'b1;
      wait_until(e + 3);
      bus.btn_next = 1'b0;
      wait_until(e + 15);
      check_eq("glitch_sel", 32'(bus.sel_out), 32'd0);

      // Manual stepping with wrap
      press_next(2'd1);
      press_next(2'd2);
      press_next(2'd3);
      press_next(2'd0);
      check_eq("wrap_sel", 32'(bus.sel_out), 32'd0);

      // Auto-scan: dwell=3, then dwell=0, then dwell=3 with a mid-count next
      e = cyc;
      bus.btn_mode = 1'b1;
      m = e + 7;
      push_exp(2'd1, m + 4);
      push_exp(2'd2, m + 8);
      push_exp(2'd3, m + 12);
      wait_until(e + 8);
      bus.btn_mode = 1'b0;
      check_eq("mode_auto", 32'(bus.mode), 32'd1);
      wait_until(m + 12);
      bus.dwell = 8'd0;
      push_exp(2'd0, m + 13);
      push_exp(2'd1, m + 14);
      push_exp(2'd2, m + 15);
      push_exp(2'd3, m + 16);
      wait_until(m + 16);
      bus.dwell = 8'd3;
      push_exp(2'd0, m + 20);
      push_exp(2'd1, m + 24);
      push_exp(2'd2, m + 28);
      push_exp(2'd3, m + 32);
      wait_until(m + 26);
      bus.btn_next = 1'b1;
      push_exp(2'd0, m + 33);
      push_exp(2'd1, m + 37);
      push_exp(2'd2, m + 41);
      wait_until(m + 34);
      bus.btn_next = 1'b0;

      // Freeze with sel=10, disp=0x1234
      wait_until(m + 36);
      bus.btn_mode = 1'b1;
      wait_until(m + 43);
      bus.btn_mode = 1'b0;
      check_eq("mode_freeze", 32'(bus.mode), 32'd2);
      check_eq("frz_sel", 32'(bus.sel_out), 32'd2);
      check_eq("frz_disp", bus.disp, 32'h0000_1234);
      check_eq("auto_drain", 32'(sb_q.size()), 32'd0);
      words[2] = 32'h5555_5555;
      wait_until(m + 46);
      bus.btn_next = 1'b1;
      wait_until(m + 56);
      bus.btn_next = 1'b0;
      wait_until(m + 66);
      check_eq("frz_hold_sel", 32'(bus.sel_out), 32'd2);
      check_eq("frz_hold_mode", 32'(bus.mode), 32'd2);
      check_eq("frz_hold_disp", bus.disp, 32'h0000_1234);
      check_eq("frz_hold_valid", 32'(bus.disp_valid), 32'd1);

      // Leave freeze: capture resumes one edge after the mode change
      e = cyc;
      bus.btn_mode = 1'b1;
      wait_until(e + 7);
      check_eq("unfrz_mode", 32'(bus.mode), 32'd0);
      check_eq("unfrz_disp_held", bus.disp, 32'h0000_1234);
      wait_until(e + 8);
      bus.btn_mode = 1'b0;
      check_eq("unfrz_disp_new", bus.disp, 32'h5555_5555);
      check_eq("unfrz_valid", 32'(bus.disp_valid), 32'd1);
      wait_until(e + 20);

      // Simultaneous next+mode in MANUAL: mode wins
      e = cyc;
      bus.btn_next = 1'b1;
      bus.btn_mode = 1'b1;
      push_exp(2'd3, e + 11);
      wait_until(e + 7);
      check_eq("simul_mode", 32'(bus.mode), 32'd1);
      check_eq("simul_sel", 32'(bus.sel_out), 32'd2);
      wait_until(e + 8);
      bus.btn_next = 1'b0;
      bus.btn_mode = 1'b0;
      wait_until(e + 13);
      check_eq("pre_rst_sel", 32'(bus.sel_out), 32'd3);

      // Reset mid-AUTO (cnt=2, sel=11) acts immediately
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_eq("mrst_sel", 32'(bus.sel_out), 32'd0);
      check_eq("mrst_mode", 32'(bus.mode), 32'd0);
      check_eq("mrst_disp", bus.disp, 32'd0);
      check_eq("mrst_valid", 32'(bus.disp_valid), 32'd0);
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = cyc;
      wait_until(k + 1);
      check_eq("mrst_cap_disp", bus.disp, 32'hDEAD_BEEF);
      check_eq("mrst_cap_valid", 32'(bus.disp_valid), 32'd1);
      mon_en = 1'b1;
      wait_until(k + 11);
      check_eq("idle_sel", 32'(bus.sel_out), 32'd0);
      check_eq("idle_mode", 32'(bus.mode), 32'd0);
      check_eq("final_drain", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dbg_out_sequencer.md
# dbg_out_sequencer

Controller for the debug output selector. It drives the selector's 2-bit select from two raw push-buttons (next, mode) and supports manual stepping, timed auto-scan and freeze. It registers the selected 32-bit word into a stable display latch. The block sits between the board buttons and the combinational PC / IM-instruction / ID-instruction / DATA selector, whose output feeds back in as `mux_out`.

## Interface
Parameters:
- D_SIZE, 32, width of selector output and display latch
- DB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1)
- DWELL_W, 8, width of auto-scan dwell setting and counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_next  in  1  raw button, steps selection
- btn_mode  in  1  raw button, cycles mode
- dwell  in  DWELL_W  auto-scan dwell; selection advances every dwell+1 cycles
- mux_out  in  D_SIZE  combinational selector output for the current sel_out
- sel_out  out  2  select to selector: 00 PC, 01 IM instr, 10 ID instr, 11 DATA
- mode  out  2  00 MANUAL, 01 AUTO, 10 FREEZE (11 unused, recovers to MANUAL)
- disp  out  D_SIZE  registered display word
- disp_valid  out  1  disp corresponds to current sel_out

## Operation
- Reset values: sel_out=00, mode=MANUAL, disp=0, disp_valid=0. All sync flops, debounce counters and debounced levels are 0. Dwell counter is 0.
- Per button: 2-flop synchronizer, then debounce. The counter increments while the synced level differs from the debounced level and clears when they match. On reaching DB_CYCLES, the debounced level takes the synced value and the counter clears. The rising edge of the debounced level gives a one-cycle pulse (next_p, mode_p). Falling edges give no pulse.
- Mode FSM on mode_p: MANUAL→AUTO→FREEZE→MANUAL. Illegal state 11 → MANUAL on the next edge.
- If mode_p and next_p occur in the same cycle, mode_p wins and next_p is dropped.
- MANUAL: next_p → sel_out = sel_out+1 mod 4 (11→00 wraps).
- AUTO:
  - Each cycle, if cnt >= dwell, sel_out increments mod 4 and cnt clears; otherwise cnt increments.
  - next_p also increments sel_out and clears cnt.
  - The >= compare tolerates dwell being lowered mid-count.
  - dwell=0 advances sel_out every cycle.
- cnt clears on entering or leaving AUTO.
- FREEZE: sel_out, disp and disp_valid are held. next_p is ignored.
- Display latch, outside FREEZE:
  - disp <= mux_out on every edge.
  - disp_valid <= 0 on the edge where sel_out changes, and 1 on every other edge.
  - Net effect: disp_valid is low for exactly one cycle after each select change.
- Entering FREEZE keeps the disp already captured. Leaving FREEZE resumes capture on the next edge.

## Timing
- The selector is combinational, so mux_out is valid the same cycle sel_out changes. disp reflects the new selection one edge later.
- Raw button rise before edge 1, held stable: synced level at edge 2, debounced level at edge 2+DB_CYCLES, pulse during the following cycle, action at edge 3+DB_CYCLES.
- A raw glitch shorter than DB_CYCLES synced cycles produces no pulse.
- Auto-scan period is dwell+1 cycles, measured between sel_out changes with no next_p.
- Reset asserted mid-operation (any mode, mid-debounce, mid-dwell) forces all reset values immediately. The first edge after release gives disp=mux_out, disp_valid=1.

## Test plan
- Reset/capture: rst_n low, mux_out=0xDEAD_BEEF. Then release → sel_out=00, mode=00, disp=0, disp_valid=0 during reset; first edge after release gives disp=0xDEAD_BEEF, disp_valid=1.
- Debounce (DB_CYCLES=4):
  - btn_next high for 3 cycles then low → sel_out unchanged.
  - btn_next held high → sel_out 00→01 at edge 7 after the rise, disp_valid low for one cycle.
  - Four separate presses → sel_out wraps 00→01→10→11→00.
- Auto-scan: press mode once (mode=01), dwell=3 → sel_out advances every 4 cycles. Set dwell=0 → advances every cycle. A next press mid-count advances immediately and restarts the 4-cycle period.
- Freeze: in AUTO with sel_out=10 and disp=0x0000_1234, press mode → mode=10. Then change mux_out to 0x5555_5555 and press next → sel_out=10, disp=0x0000_1234, disp_valid=1 held. Press mode again → MANUAL, disp=0x5555_5555 next edge.
- Simultaneous: next_p and mode_p in the same cycle in MANUAL → mode becomes 01, sel_out unchanged.
- Reset mid-AUTO with cnt=2 and sel_out=11 → immediate sel_out=00, mode=00. Afterward, 10 idle cycles → no sel_out change.
